det_seq: RTL

Sequential signed determinant engine for 2x2 and 3x3 matrices, selectable per operation. Uses one shared multiplier/accumulator and cofactor expansion along row 0.
Sits in the matrix coprocessor datapath beside the other matrix ops and is driven by the command decoder with a start/done handshake.
Supports parametrised element and result widths, wide plus narrowed results, and an overflow flag.

---
 rtl/det_if.sv | 49 ++++
 rtl/det_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/det_if.sv
`default_nettype none
// ============================================================================
//  Module      : det_if
//  Description : Command/result bundle between the command decoder and the
//                det_seq determinant engine. The decoder side (master)
//                drives the request; the engine side (slave) returns status
//                and results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface det_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8,
    parameter int ACC_W  = 3*DATA_W+3
);
    // Request: start pulse, matrix size select, row-major matrix elements
    logic                  start;
    logic                  size;
    logic [9*DATA_W-1:0]   mat;

    // Status and results
    logic                  busy;
    logic                  done;
    logic [ACC_W-1:0]      det_full;
    logic [OUT_W-1:0]      det;
    logic                  ovf;

    modport master (
        output start,
        output size,
        output mat,
        input  busy,
        input  done,
        input  det_full,
        input  det,
        input  ovf
    );

    modport slave (
        input  start,
        input  size,
        input  mat,
        output busy,
        output done,
        output det_full,
        output det,
        output ovf
    );
endinterface
`default_nettype wire

// File: rtl/det_seq.sv
`default_nettype none
// ============================================================================
//  Module      : det_seq
//  Description : Sequential signed determinant engine for 2x2 and 3x3
//                matrices. One shared multiplier is time-multiplexed between
//                minor products and row-0 cofactor scaling. Latency is fixed:
//                done rises 3 edges (2x2) or 10 edges (3x3) after start is
//                sampled.
//                Build option: define DET_SAT_EN to clamp the narrowed result
//                det on overflow; otherwise det wraps (low OUT_W bits).
//                ACC_W must be at least 3*DATA_W+3 for exact results.
//  Revision    : 1.0 - initial release
// ============================================================================
module det_seq #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8,
    parameter int ACC_W  = 3*DATA_W+3
) (
    input  wire logic clk,
    input  wire logic rst,
    det_if.slave      bus
);

    // ------------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------------
    // A 2x2 minor (difference of two element products) needs one bit more
    // than a single product; the shared multiplier therefore takes an element
    // on one side and a minor-wide operand on the other.
    localparam int MW = 2*DATA_W+1;
    localparam int PW = DATA_W+MW;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MINOR_A = 3'd1;
    localparam logic [2:0] S_MINOR_B = 3'd2;
    localparam logic [2:0] S_SCALE   = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    localparam logic [1:0] c_LAST_COL = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]                     r_state;
    logic [1:0]                     r_col;
    logic                           r_size;
    logic [8:0][DATA_W-1:0]         r_mat;
    logic signed [ACC_W-1:0]        r_acc;
    logic signed [MW-1:0]           r_minor;
    logic                           r_done;
    logic [ACC_W-1:0]               r_det_full;
    logic [OUT_W-1:0]               r_det;
    logic                           r_ovf;

    // ------------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------------
    logic [1:0]                     w_col_p;
    logic [1:0]                     w_col_q;
    logic [1:0]                     w_row_hi;
    logic [1:0]                     w_row_lo;
    logic [1:0]                     w_row_a;
    logic [1:0]                     w_col_a;
    logic [1:0]                     w_row_b;
    logic [1:0]                     w_col_b;
    logic [3:0]                     w_idx_a;
    logic [3:0]                     w_idx_b;
    logic [DATA_W-1:0]              w_elem_a;
    logic [DATA_W-1:0]              w_elem_b;
    logic signed [DATA_W-1:0]       w_mul_a;
    logic signed [MW-1:0]           w_mul_b;
    logic signed [PW-1:0]           w_prod;
    logic signed [MW-1:0]           w_prod_minor;
    logic signed [ACC_W-1:0]        w_prod_ext;
    logic [OUT_W-1:0]               w_det_next;
    logic                           w_ovf;

    // ------------------------------------------------------------------------
    // Minor column pair (p<q, both != j) and the two rows feeding the minor.
    // A 2x2 op reuses the same machinery with rows 0/1 and columns 0/1, so
    // a00*a11 - a01*a10 falls out of the MINOR_A/MINOR_B pair directly.
    // ------------------------------------------------------------------------
    always_comb begin
        w_col_p  = 2'd0;
        w_col_q  = 2'd1;
        w_row_hi = 2'd0;
        w_row_lo = 2'd1;
        if (r_size) begin
            w_row_hi = 2'd1;
            w_row_lo = 2'd2;
            case (r_col)
                2'd0: begin
                    w_col_p = 2'd1;
                    w_col_q = 2'd2;
                end
                2'd1: begin
                    w_col_p = 2'd0;
                    w_col_q = 2'd2;
                end
                default: begin
                    w_col_p = 2'd0;
                    w_col_q = 2'd1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Multiplier operand steering: first minor product, second minor
    // product, or row-0 element times the finished minor.
    // ------------------------------------------------------------------------
    always_comb begin
        w_row_a = w_row_hi;
        w_col_a = w_col_p;
        w_row_b = w_row_lo;
        w_col_b = w_col_q;
        case (r_state)
            S_MINOR_B: begin
                w_row_a = w_row_hi;
                w_col_a = w_col_q;
                w_row_b = w_row_lo;
                w_col_b = w_col_p;
            end
            S_SCALE: begin
                w_row_a = 2'd0;
                w_col_a = r_col;
                w_row_b = w_row_lo;
                w_col_b = w_col_q;
            end
            default: begin
                w_row_a = w_row_hi;
                w_col_a = w_col_p;
                w_row_b = w_row_lo;
                w_col_b = w_col_q;
            end
        endcase
    end

    // Row-major flat index r*3+c into the latched matrix
    assign w_idx_a  = ({2'b00, w_row_a} * 4'd3) + {2'b00, w_col_a};
    assign w_idx_b  = ({2'b00, w_row_b} * 4'd3) + {2'b00, w_col_b};
    assign w_elem_a = r_mat[w_idx_a];
    assign w_elem_b = r_mat[w_idx_b];

    // Shared signed multiplier; the second operand is either a sign-extended
    // element or the minor accumulated in r_minor.
    assign w_mul_a  = $signed(w_elem_a);
    assign w_mul_b  = (r_state == S_SCALE) ? r_minor
                    : $signed({{(MW-DATA_W){w_elem_b[DATA_W-1]}}, w_elem_b});
    assign w_prod   = w_mul_a * w_mul_b;

    // Element*element products fit in MW bits, so the low slice is exact
    assign w_prod_minor = $signed(w_prod[MW-1:0]);
    assign w_prod_ext   = $signed({{(ACC_W-PW){w_prod[PW-1]}}, w_prod});

    // ------------------------------------------------------------------------
    // Narrowing and overflow detection on the final accumulator value.
    // The value fits OUT_W exactly when every bit from OUT_W-1 upward equals
    // the sign bit.
    // ------------------------------------------------------------------------
    if (OUT_W < ACC_W) begin : g_narrow
        logic [OUT_W-1:0] w_wrap;
        logic [OUT_W-1:0] w_sat_max;
        logic [OUT_W-1:0] w_sat_min;

        assign w_wrap    = r_acc[OUT_W-1:0];
        assign w_sat_max = {1'b0, {(OUT_W-1){1'b1}}};
        assign w_sat_min = {1'b1, {(OUT_W-1){1'b0}}};
        assign w_ovf     = (|r_acc[ACC_W-1:OUT_W-1]) & ~(&r_acc[ACC_W-1:OUT_W-1]);
`ifdef DET_SAT_EN
        assign w_det_next = w_ovf ? (r_acc[ACC_W-1] ? w_sat_min : w_sat_max)
                                  : w_wrap;
`else
        assign w_det_next = w_wrap;
`endif
    end else if (OUT_W == ACC_W) begin : g_equal
        assign w_ovf      = 1'b0;
        assign w_det_next = r_acc;
    end else begin : g_widen
        assign w_ovf      = 1'b0;
        assign w_det_next = {{(OUT_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
    end

    // ------------------------------------------------------------------------
    // Control FSM: sequencing of minor products, scaling and column index
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_col   <= 2'd0;
            r_size  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_size  <= bus.size;
                        r_col   <= 2'd0;
                        r_state <= S_MINOR_A;
                    end
                end
                S_MINOR_A: begin
                    r_state <= S_MINOR_B;
                end
                S_MINOR_B: begin
                    r_state <= r_size ? S_SCALE : S_FINISH;
                end
                S_SCALE: begin
                    if (r_col == c_LAST_COL) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_col   <= r_col + 2'd1;
                        r_state <= S_MINOR_A;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: operand latch, minor register and determinant accumulator
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mat   <= '0;
            r_acc   <= '0;
            r_minor <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mat   <= bus.mat;
                        r_acc   <= '0;
                        r_minor <= '0;
                    end
                end
                S_MINOR_A: begin
                    if (r_size) begin
                        r_minor <= w_prod_minor;
                    end else begin
                        r_acc   <= w_prod_ext;
                    end
                end
                S_MINOR_B: begin
                    if (r_size) begin
                        r_minor <= r_minor - w_prod_minor;
                    end else begin
                        r_acc   <= r_acc - w_prod_ext;
                    end
                end
                S_SCALE: begin
                    // Cofactor sign alternates +,-,+ along row 0
                    if (r_col == 2'd1) begin
                        r_acc <= r_acc - w_prod_ext;
                    end else begin
                        r_acc <= r_acc + w_prod_ext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Result registers and done pulse; results hold until the next FINISH
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done     <= 1'b0;
            r_det_full <= '0;
            r_det      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_FINISH) begin
                r_det_full <= r_acc;
                r_det      <= w_det_next;
                r_ovf      <= w_ovf;
                r_done     <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.det_full = r_det_full;
    assign bus.det      = r_det;
    assign bus.ovf      = r_ovf;

endmodule
`default_nettype wire
